// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - FU result, branch resolution and register-file write bundle for wb_arbiter
interface wb_arbiter_if #(
  parameter int NUM_FU   = 4,
  parameter int WB_PORTS = 2,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5
);
  logic [NUM_FU-1:0]          fu_valid;
  logic [NUM_FU*DATA_W-1:0]   fu_data;
  logic [NUM_FU*REG_W-1:0]    fu_reg;
  logic [NUM_FU-1:0]          fu_spec;
  logic [NUM_FU-1:0]          fu_ready;
  logic                       branch_mispredict;
  logic                       branch_correct;
  logic [WB_PORTS-1:0]        wb_en;
  logic [WB_PORTS*DATA_W-1:0] wb_data;
  logic [WB_PORTS*REG_W-1:0]  wb_reg;

  modport master (
    output fu_valid, fu_data, fu_reg, fu_spec, branch_mispredict, branch_correct,
    input  fu_ready, wb_en, wb_data, wb_reg
  );

  modport slave (
    input  fu_valid, fu_data, fu_reg, fu_spec, branch_mispredict, branch_correct,
    output fu_ready, wb_en, wb_data, wb_reg
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - per-FU result FIFOs with speculation tracking and round-robin writeback arbitration
module wb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int WB_PORTS   = 2,
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int FIFO_DEPTH = 2
) (
  input logic         CLK,
  input logic         nRST,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              spec;
  } entry_t;

  entry_t                     fifo_q [NUM_FU][FIFO_DEPTH];
  entry_t                     fifo_d [NUM_FU][FIFO_DEPTH];
  logic [CNT_W-1:0]           cnt_q  [NUM_FU];
  logic [CNT_W-1:0]           cnt_d  [NUM_FU];
  logic [PTR_W-1:0]           rr_q, rr_d;
  logic [WB_PORTS-1:0]        wb_en_q, wb_en_d;
  logic [WB_PORTS*DATA_W-1:0] wb_data_q, wb_data_d;
  logic [WB_PORTS*REG_W-1:0]  wb_reg_q, wb_reg_d;

  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] grant;
  int                arb_ports;
  int                arb_last;
  int                fill;

  always_comb begin
    ready    = '0;
    eligible = '0;
    for (int c = 0; c < NUM_FU; c++) begin
      ready[c]    = cnt_q[c] < CNT_W'(FIFO_DEPTH);
      eligible[c] = (cnt_q[c] != '0) && !fifo_q[c][0].spec;
    end
  end

  // Walk channels in rotated order; the k-th eligible one (k < WB_PORTS) lands on port k.
  always_comb begin
    grant     = '0;
    wb_en_d   = '0;
    wb_data_d = '0;
    wb_reg_d  = '0;
    arb_ports = 0;
    arb_last  = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int c = 0; c < NUM_FU; c++) begin
        if (c == (int'(rr_q) + k) % NUM_FU && eligible[c] && arb_ports < WB_PORTS) begin
          grant[c] = 1'b1;
          for (int p = 0; p < WB_PORTS; p++) begin
            if (p == arb_ports) begin
              wb_en_d[p]                       = 1'b1;
              wb_data_d[p*DATA_W +: DATA_W]    = fifo_q[c][0].data;
              wb_reg_d[p*REG_W +: REG_W]       = fifo_q[c][0].rd;
            end
          end
          arb_ports = arb_ports + 1;
          arb_last  = c;
        end
      end
    end
    rr_d = (arb_ports != 0) ? PTR_W'((arb_last + 1) % NUM_FU) : rr_q;
  end

  // Rebuild each FIFO as: surviving entries (minus granted head, minus flushed spec), then the new entry.
  always_comb begin
    fill = 0;
    for (int c = 0; c < NUM_FU; c++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_d[c][j] = fifo_q[c][j];
      end
      fill = 0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        if (k < int'(cnt_q[c]) && !(k == 0 && grant[c]) &&
            !(bus.branch_mispredict && fifo_q[c][k].spec)) begin
          for (int j = 0; j < FIFO_DEPTH; j++) begin
            if (j == fill) fifo_d[c][j] = fifo_q[c][k];
          end
          fill = fill + 1;
        end
      end
      if (bus.fu_valid[c] && ready[c] && bus.fu_reg[c*REG_W +: REG_W] != '0 &&
          !(bus.branch_mispredict && bus.fu_spec[c])) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          if (j == fill) begin
            fifo_d[c][j] = {bus.fu_data[c*DATA_W +: DATA_W], bus.fu_reg[c*REG_W +: REG_W], bus.fu_spec[c]};
          end
        end
        fill = fill + 1;
      end
      if (bus.branch_correct) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          fifo_d[c][j].spec = 1'b0;
        end
      end
      cnt_d[c] = CNT_W'(fill);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < NUM_FU; c++) begin
        cnt_q[c] <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          fifo_q[c][j] <= '0;
        end
      end
      rr_q      <= '0;
      wb_en_q   <= '0;
      wb_data_q <= '0;
      wb_reg_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_FU; c++) begin
        cnt_q[c] <= cnt_d[c];
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          fifo_q[c][j] <= fifo_d[c][j];
        end
      end
      rr_q      <= rr_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
      wb_reg_q  <= wb_reg_d;
    end
  end

  assign bus.fu_ready = ready;
  assign bus.wb_en    = wb_en_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_reg   = wb_reg_q;
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised writeback stage for the scalar pipeline: collects results from NUM_FU functional units (ALU, load/store, ...) through per-unit FIFOs.
- Arbitrates up to WB_PORTS register-file writes per cycle, round-robin.
- Holds branch-speculative results until the branch resolves: released on commit, dropped on mispredict.
- Sits between the FU outputs and the register-file write ports.

Parameters:
NUM_FU, 4, number of functional-unit result channels
WB_PORTS, 2, register-file write ports driven per cycle (1..NUM_FU)
DATA_W, 32, result data width
REG_W, 5, destination register index width
FIFO_DEPTH, 2, entries per channel FIFO (power of two, >=2)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
fu_valid  in  NUM_FU  channel i presents a result
fu_data  in  NUM_FU*DATA_W  result data, channel i at [i*DATA_W +: DATA_W]
fu_reg  in  NUM_FU*REG_W  destination register, channel i at [i*REG_W +: REG_W]
fu_spec  in  NUM_FU  result issued under an unresolved branch
fu_ready  out  NUM_FU  channel i FIFO can accept
branch_mispredict  in  1  flush all speculative results
branch_correct  in  1  clear speculative state, making entries eligible
wb_en  out  WB_PORTS  write-port p valid
wb_data  out  WB_PORTS*DATA_W  write data per port
wb_reg  out  WB_PORTS*REG_W  write register per port

Behaviour:
- Reset (nRST low, async): all FIFOs empty; spec bits 0; rr_ptr=0; wb_en=0, wb_data=0, wb_reg=0; fu_ready=all 1 once reset deasserts.
- Enqueue: on a rising edge with fu_valid[i] && fu_ready[i], channel i stores {data, reg, spec}.
- fu_ready[i] = (count_i < FIFO_DEPTH), from the current count only. A full FIFO never enqueues in the same cycle it dequeues.
- Writes to reg 0 are accepted (handshake completes) but not stored.
- Eligibility: channel i is eligible when its FIFO is non-empty and the head spec bit is 0.
- Arbitration (combinational, each cycle):
  - Scan channels from rr_ptr upward, modulo NUM_FU.
  - Grant the first min(WB_PORTS, #eligible) eligible channels, in scan order, to ports 0,1,...
  - Each granted channel dequeues its head at the edge.
  - At most one entry per channel per cycle.
- rr_ptr update: if any grant, next rr_ptr = (index of last granted channel + 1) mod NUM_FU; otherwise unchanged.
- Outputs are registered.
  - Granted heads appear on wb_* in the cycle after the grant.
  - Ungranted ports drive wb_en=0 and hold data/reg at 0.
  - Min latency fu_valid -> wb_en is 2 edges: enqueue edge, then grant edge.
- branch_correct: at the edge, clear spec bits of all stored entries and of any same-cycle incoming entry.
- branch_mispredict:
  - At the edge, remove every spec=1 entry from every FIFO, compacting so non-spec order is preserved.
  - A same-cycle incoming spec=1 entry is discarded (its handshake still completes).
  - Spec entries are never granted, so no speculative write is in flight.
- branch_mispredict and branch_correct in the same cycle: mispredict wins.
- Same destination register on two ports in one cycle: the higher-numbered port holds the later-priority grant. The register file resolves so that the higher port wins.
- Per-channel order is strictly FIFO. No ordering is guaranteed across channels.
- Reset mid-operation: all state is discarded immediately and wb_en drops to 0 asynchronously.

Test Plan:
- Single result: fu_valid[0]=1, reg=5, data=0xDEADBEEF, one cycle -> wb_en[0]=1, wb_reg=5, wb_data=0xDEADBEEF exactly 2 edges later; wb_en=0 otherwise.
- Contention: all 4 channels valid same cycle (regs 1..4), WB_PORTS=2, rr_ptr=0 -> regs 1,2 written on the next write cycle, then regs 3,4; rr_ptr ends at 0.
- Backpressure: hold channel 1 valid 3 cycles while its grants are starved by channels 0/2/3 -> fu_ready[1]=0 after 2 accepts; no data lost; order preserved.
- Speculation commit: channel 2 enqueues spec results reg 7, 8 -> no wb for 5 cycles. Pulse branch_correct -> reg 7 and reg 8 written in order.
- Mispredict flush:
  - Channel 0 holds [non-spec reg 3, spec reg 4]; pulse branch_mispredict together with a new spec input.
  - Only reg 3 is written; the FIFO is empty afterwards.
  - Repeat with branch_correct asserted simultaneously -> same result.
- Reset mid-traffic: assert nRST low while FIFOs hold 3 entries -> wb_en=0 immediately; after release, no stale writes and fu_ready all 1.
